// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory port arbiter.
// Contents: FSM state encoding, request owner constants, streak counter width helper.
package mem_port_arbiter_pkg;

  // One-hot FSM encoding.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StReq  = 3'b010,
    StResp = 3'b100
  } arb_state_e;

  // Owner of the transaction currently in flight.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Counter width that can hold every value 0..limit inclusive.
  function automatic int unsigned streak_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_prio_starve.sv
// Grant selection between fetch and data requests plus the anti-starvation streak counter.
// Data wins a tie unless it has already won STARVE_LIMIT ties in a row, in which case
// fetch is forced through once.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   grant_en   1 when a new grant may be issued (arbiter idle)
//   i_valid    fetch request pending
//   d_valid    data request pending
//   grant_i    fetch granted this cycle
//   grant_d    data granted this cycle
module arb_prio_starve
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

  localparam int unsigned StreakW = streak_width(STARVE_LIMIT);
  localparam logic [StreakW-1:0] Limit = StreakW'(STARVE_LIMIT);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               starved;

  assign starved = (streak_q == Limit);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (grant_en) begin
      if (d_valid && !(i_valid && starved)) begin
        grant_d = 1'b1;
      end else if (i_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  // Streak counts data grants that left fetch waiting; any grant that does not
  // leave fetch waiting resets it.
  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      streak_d = '0;
    end else if (grant_d) begin
      if (!i_valid) begin
        streak_d = '0;
      end else if (!starved) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch (read-only) and
// load/store (read/write). One transaction outstanding at a time: IDLE grants,
// REQ presents the registered request, RESP forwards read data to the owner.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   I_Addr, I_Req_Valid/I_Req_Ready   fetch request
//   I_Rdata, I_Rvalid/I_Rready        fetch response
//   D_Addr, D_Write, D_Wdata, D_Wstrb data request fields
//   D_Req_Valid/D_Req_Ready           data request handshake
//   D_Rdata, D_Rvalid/D_Rready        load response
//   M_Addr, M_Write, M_Wdata, M_Wstrb registered request to memory
//   M_Req_Valid/M_Req_Ready           memory request handshake
//   M_Rdata, M_Rvalid/M_Rready        memory read response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   I_Addr,
  input  logic                I_Req_Valid,
  output logic                I_Req_Ready,
  output logic [DATA_W-1:0]   I_Rdata,
  output logic                I_Rvalid,
  input  logic                I_Rready,
  input  logic [ADDR_W-1:0]   D_Addr,
  input  logic                D_Write,
  input  logic [DATA_W-1:0]   D_Wdata,
  input  logic [DATA_W/8-1:0] D_Wstrb,
  input  logic                D_Req_Valid,
  output logic                D_Req_Ready,
  output logic [DATA_W-1:0]   D_Rdata,
  output logic                D_Rvalid,
  input  logic                D_Rready,
  output logic [ADDR_W-1:0]   M_Addr,
  output logic                M_Write,
  output logic [DATA_W-1:0]   M_Wdata,
  output logic [DATA_W/8-1:0] M_Wstrb,
  output logic                M_Req_Valid,
  input  logic                M_Req_Ready,
  input  logic [DATA_W-1:0]   M_Rdata,
  input  logic                M_Rvalid,
  output logic                M_Rready
);

  arb_state_e state_q, state_d;

  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  logic grant_en, grant_i, grant_d, rsp_ready;

  // Gated by rst so no ready is visible while reset is held.
  assign grant_en = (state_q == StIdle) && !rst;

  arb_prio_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .grant_en(grant_en),
    .i_valid (I_Req_Valid),
    .d_valid (D_Req_Valid),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    I_Req_Ready = grant_i;
    D_Req_Ready = grant_d;
    M_Req_Valid = 1'b0;
    rsp_ready   = 1'b0;
    I_Rvalid    = 1'b0;
    D_Rvalid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_i || grant_d) begin
          state_d = StReq;
        end
      end
      StReq: begin
        M_Req_Valid = 1'b1;
        if (M_Req_Ready) begin
          // Stores complete on request acceptance; no response follows.
          state_d = write_q ? StIdle : StResp;
        end
      end
      StResp: begin
        rsp_ready = (owner_q == OWNER_D) ? D_Rready : I_Rready;
        I_Rvalid  = (owner_q == OWNER_I) && M_Rvalid;
        D_Rvalid  = (owner_q == OWNER_D) && M_Rvalid;
        if (M_Rvalid && rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign M_Rready = rsp_ready;
  assign I_Rdata  = M_Rdata;
  assign D_Rdata  = M_Rdata;
  assign M_Addr   = addr_q;
  assign M_Write  = write_q;
  assign M_Wdata  = wdata_q;
  assign M_Wstrb  = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OWNER_I;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_q <= OWNER_D;
        addr_q  <= D_Addr;
        write_q <= D_Write;
        wdata_q <= D_Wdata;
        wstrb_q <= D_Wstrb;
      end else if (grant_i) begin
        owner_q <= OWNER_I;
        addr_q  <= I_Addr;
        write_q <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] I_Addr = '0;
  logic        I_Req_Valid = 1'b0;
  logic        I_Req_Ready;
  logic [31:0] I_Rdata;
  logic        I_Rvalid;
  logic        I_Rready = 1'b1;
  logic [31:0] D_Addr = '0;
  logic        D_Write = 1'b0;
  logic [31:0] D_Wdata = '0;
  logic [3:0]  D_Wstrb = '0;
  logic        D_Req_Valid = 1'b0;
  logic        D_Req_Ready;
  logic [31:0] D_Rdata;
  logic        D_Rvalid;
  logic        D_Rready = 1'b1;
  logic [31:0] M_Addr;
  logic        M_Write;
  logic [31:0] M_Wdata;
  logic [3:0]  M_Wstrb;
  logic        M_Req_Valid;
  logic        M_Req_Ready = 1'b0;
  logic [31:0] M_Rdata = '0;
  logic        M_Rvalid = 1'b0;
  logic        M_Rready;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .I_Addr     (I_Addr),
    .I_Req_Valid(I_Req_Valid),
    .I_Req_Ready(I_Req_Ready),
    .I_Rdata    (I_Rdata),
    .I_Rvalid   (I_Rvalid),
    .I_Rready   (I_Rready),
    .D_Addr     (D_Addr),
    .D_Write    (D_Write),
    .D_Wdata    (D_Wdata),
    .D_Wstrb    (D_Wstrb),
    .D_Req_Valid(D_Req_Valid),
    .D_Req_Ready(D_Req_Ready),
    .D_Rdata    (D_Rdata),
    .D_Rvalid   (D_Rvalid),
    .D_Rready   (D_Rready),
    .M_Addr     (M_Addr),
    .M_Write    (M_Write),
    .M_Wdata    (M_Wdata),
    .M_Wstrb    (M_Wstrb),
    .M_Req_Valid(M_Req_Valid),
    .M_Req_Ready(M_Req_Ready),
    .M_Rdata    (M_Rdata),
    .M_Rvalid   (M_Rvalid),
    .M_Rready   (M_Rready)
  );

  always #5 clk = ~clk;

  // Memory model: read data is the address XOR 0xC0DE0000, except 0x100 holds a NOP.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  int          req_wait = 0;
  int          rsp_wait = 0;
  int          req_cnt = 0;
  int          rsp_cnt = 0;
  bit          pend = 0;
  bit          req_hs = 0;
  bit          rsp_hs = 0;
  logic [31:0] lat_addr = '0;
  logic        lat_wr = 1'b0;

  // Handshake levels are stable across the whole low phase, so record them here.
  always @(negedge clk) begin
    req_hs = M_Req_Valid && M_Req_Ready;
    rsp_hs = M_Rvalid && M_Rready;
  end

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      M_Req_Ready = 1'b0;
      M_Rvalid    = 1'b0;
      pend        = 0;
      req_cnt     = 0;
      rsp_cnt     = 0;
    end else begin
      if (req_hs) begin
        M_Req_Ready = 1'b0;
        req_cnt     = 0;
        if (!lat_wr) begin
          pend    = 1;
          rsp_cnt = 0;
        end
      end else if (M_Req_Valid && !M_Req_Ready) begin
        if (req_cnt >= req_wait) begin
          M_Req_Ready = 1'b1;
          lat_addr    = M_Addr;
          lat_wr      = M_Write;
        end else begin
          req_cnt++;
        end
      end
      if (rsp_hs) M_Rvalid = 1'b0;
      if (pend) begin
        if (rsp_cnt >= rsp_wait) begin
          M_Rvalid = 1'b1;
          M_Rdata  = mem_rd(lat_addr);
          pend     = 0;
        end else begin
          rsp_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Inputs change 2 time units after the active edge; the memory model moves at 1.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Waits for the owner's Rvalid (with Rready high) and steps through the handshake edge.
  task automatic wait_rsp(input bit is_d, output bit ok, output logic [31:0] d);
    ok = 0;
    d  = '0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (is_d ? D_Rvalid : I_Rvalid) begin
        ok = 1;
        d  = is_d ? D_Rdata : I_Rdata;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    I_Req_Valid = 1'b1;
    D_Req_Valid = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (I_Req_Ready !== 1'b0 || D_Req_Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_ready: got I=%b D=%b want 0 0", I_Req_Ready, D_Req_Ready);
    end
    checks++;
    if (M_Req_Valid !== 1'b0 || M_Rready !== 1'b0 || I_Rvalid !== 1'b0 || D_Rvalid !== 1'b0)
    begin
      failures++;
      $display("FAIL reset_valids: got mv=%b mr=%b iv=%b dv=%b want 0", M_Req_Valid, M_Rready,
               I_Rvalid, D_Rvalid);
    end
    checks++;
    if (M_Addr !== 32'h0 || M_Wdata !== 32'h0 || M_Wstrb !== 4'h0 || M_Write !== 1'b0) begin
      failures++;
      $display("FAIL reset_fields: got addr=%h wdata=%h strb=%h wr=%b want 0", M_Addr, M_Wdata,
               M_Wstrb, M_Write);
    end
    checks++;
    if (dut.state_q !== StIdle || dut.u_prio.streak_q !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got state=%b streak=%0d want 001 0", dut.state_q,
               dut.u_prio.streak_q);
    end
    I_Req_Valid = 1'b0;
    D_Req_Valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    int          seen_i;
    int          seen_d;
    logic [31:0] data;
    rsp_wait = 2;
    I_Addr = 32'h100;
    I_Req_Valid = 1'b1;
    #1;
    checks++;
    if (I_Req_Ready !== 1'b1 || M_Req_Valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_grant: got rdy=%b mvalid=%b want 1 0", I_Req_Ready, M_Req_Valid);
    end
    step();
    I_Req_Valid = 1'b0;
    #1;
    checks++;
    if (M_Req_Valid !== 1'b1 || M_Addr !== 32'h100 || M_Write !== 1'b0) begin
      failures++;
      $display("FAIL fetch_mreq: got v=%b addr=%h wr=%b want 1 00000100 0", M_Req_Valid, M_Addr,
               M_Write);
    end
    checks++;
    if (I_Req_Ready !== 1'b0) begin
      failures++;
      $display("FAIL fetch_no_regrant: got %b want 0", I_Req_Ready);
    end
    seen_i = 0;
    seen_d = 0;
    data   = '0;
    for (int c = 0; c < 12; c++) begin
      if (I_Rvalid) begin
        seen_i++;
        data = I_Rdata;
      end
      if (D_Rvalid) seen_d++;
      step();
    end
    checks++;
    if (seen_i != 1 || data !== 32'h0000_0013) begin
      failures++;
      $display("FAIL fetch_rsp: got count=%0d data=%h want 1 00000013", seen_i, data);
    end
    checks++;
    if (seen_d != 0) begin
      failures++;
      $display("FAIL fetch_no_d_rvalid: got %0d want 0", seen_d);
    end
    rsp_wait = 0;
  endtask

  task automatic test_priority();
    bit          ok;
    bit          found;
    logic [31:0] data;
    I_Addr = 32'h200;
    I_Req_Valid = 1'b1;
    D_Addr = 32'h8000;
    D_Write = 1'b0;
    D_Req_Valid = 1'b1;
    #1;
    checks++;
    if (D_Req_Ready !== 1'b1 || I_Req_Ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_grant: got D=%b I=%b want 1 0", D_Req_Ready, I_Req_Ready);
    end
    step();
    D_Req_Valid = 1'b0;
    #1;
    checks++;
    if (M_Addr !== 32'h8000 || M_Req_Valid !== 1'b1) begin
      failures++;
      $display("FAIL prio_d_addr: got %h v=%b want 00008000 1", M_Addr, M_Req_Valid);
    end
    wait_rsp(1'b1, ok, data);
    checks++;
    if (!ok || data !== 32'hC0DE_8000) begin
      failures++;
      $display("FAIL prio_d_rsp: got ok=%b data=%h want 1 c0de8000", ok, data);
    end
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (I_Req_Ready) found = 1;
      else step();
    end
    step();
    I_Req_Valid = 1'b0;
    #1;
    checks++;
    if (!found || M_Addr !== 32'h200) begin
      failures++;
      $display("FAIL prio_i_addr: got found=%b addr=%h want 1 00000200", found, M_Addr);
    end
    wait_rsp(1'b0, ok, data);
    checks++;
    if (!ok || data !== 32'hC0DE_0200) begin
      failures++;
      $display("FAIL prio_i_rsp: got ok=%b data=%h want 1 c0de0200", ok, data);
    end
  endtask

  task automatic test_store();
    bit found;
    D_Addr = 32'h8004;
    D_Write = 1'b1;
    D_Wdata = 32'hDEAD_BEEF;
    D_Wstrb = 4'hF;
    D_Req_Valid = 1'b1;
    #1;
    checks++;
    if (D_Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL store_grant: got %b want 1", D_Req_Ready);
    end
    step();
    D_Req_Valid = 1'b0;
    #1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (M_Req_Ready) found = 1;
      else step();
    end
    checks++;
    if (!found || M_Addr !== 32'h8004 || M_Wdata !== 32'hDEAD_BEEF || M_Wstrb !== 4'hF ||
        M_Write !== 1'b1) begin
      failures++;
      $display("FAIL store_fields: got ok=%b addr=%h wdata=%h strb=%h wr=%b want 1 8004 deadbeef f 1",
               found, M_Addr, M_Wdata, M_Wstrb, M_Write);
    end
    step();
    checks++;
    if (dut.state_q !== StIdle || M_Req_Valid !== 1'b0 || M_Rready !== 1'b0) begin
      failures++;
      $display("FAIL store_idle: got state=%b mv=%b mr=%b want 001 0 0", dut.state_q, M_Req_Valid,
               M_Rready);
    end
    D_Write = 1'b0;
  endtask

  task automatic test_starve();
    bit exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit found;
    bit got_i;
    I_Addr = 32'h300;
    I_Req_Valid = 1'b1;
    D_Addr = 32'h9000;
    D_Write = 1'b1;
    D_Wdata = 32'h1111_2222;
    D_Wstrb = 4'hF;
    D_Req_Valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      found = 0;
      got_i = 0;
      for (int c = 0; c < 30 && !found; c++) begin
        if (D_Req_Ready || I_Req_Ready) begin
          found = 1;
          got_i = I_Req_Ready;
        end else begin
          step();
        end
      end
      checks++;
      if (!found || got_i !== exp_i[g]) begin
        failures++;
        $display("FAIL starve_grant%0d: got found=%b is_fetch=%b want 1 %b", g, found, got_i,
                 exp_i[g]);
      end
      step();
      if (g == 3) begin
        checks++;
        if (dut.u_prio.streak_q !== 3'd4) begin
          failures++;
          $display("FAIL starve_streak: got %0d want 4", dut.u_prio.streak_q);
        end
      end
      if (got_i) I_Req_Valid = 1'b0;
      if (g == 5) D_Req_Valid = 1'b0;
      D_Addr = D_Addr + 32'd4;
    end
    repeat (6) step();
    D_Write = 1'b0;
  endtask

  task automatic test_stall();
    bit found;
    req_wait = 5;
    D_Addr = 32'h8010;
    D_Write = 1'b1;
    D_Wdata = 32'h1234_5678;
    D_Wstrb = 4'h3;
    D_Req_Valid = 1'b1;
    step();
    D_Req_Valid = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (M_Req_Valid !== 1'b1 || M_Addr !== 32'h8010 || M_Wdata !== 32'h1234_5678 ||
          M_Req_Ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b addr=%h wdata=%h want 1 8010 12345678", k,
                 M_Req_Valid, M_Addr, M_Wdata);
      end
      step();
    end
    for (int c = 0; c < 10 && !M_Req_Ready; c++) step();
    step();
    req_wait = 0;
    D_Write = 1'b0;
    I_Rready = 1'b0;
    I_Addr = 32'h400;
    I_Req_Valid = 1'b1;
    step();
    I_Req_Valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (I_Rvalid) found = 1;
      else step();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (!found || M_Rready !== 1'b0 || I_Rvalid !== 1'b1 || dut.state_q !== StResp) begin
        failures++;
        $display("FAIL stall_rready%0d: got mr=%b iv=%b state=%b want 0 1 100", k, M_Rready,
                 I_Rvalid, dut.state_q);
      end
      step();
    end
    I_Rready = 1'b1;
    #1;
    checks++;
    if (M_Rready !== 1'b1 || I_Rvalid !== 1'b1 || I_Rdata !== 32'hC0DE_0400) begin
      failures++;
      $display("FAIL stall_release: got mr=%b iv=%b data=%h want 1 1 c0de0400", M_Rready,
               I_Rvalid, I_Rdata);
    end
    step();
    checks++;
    if (dut.state_q !== StIdle) begin
      failures++;
      $display("FAIL stall_done: got state=%b want 001", dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    rsp_wait = 20;
    I_Addr = 32'h500;
    I_Req_Valid = 1'b1;
    D_Addr = 32'h8020;
    D_Write = 1'b0;
    D_Req_Valid = 1'b1;
    step();
    D_Req_Valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (dut.state_q == StResp) found = 1;
      else step();
    end
    checks++;
    if (!found || dut.u_prio.streak_q !== 3'd1) begin
      failures++;
      $display("FAIL rstmid_setup: got resp=%b streak=%0d want 1 1", found, dut.u_prio.streak_q);
    end
    rst = 1'b1;
    step();
    checks++;
    if (dut.state_q !== StIdle || dut.u_prio.streak_q !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_state: got state=%b streak=%0d want 001 0", dut.state_q,
               dut.u_prio.streak_q);
    end
    checks++;
    if (I_Req_Ready !== 1'b0 || D_Req_Ready !== 1'b0 || I_Rvalid !== 1'b0 ||
        D_Rvalid !== 1'b0 || M_Req_Valid !== 1'b0 || M_Rready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got ir=%b dr=%b iv=%b dv=%b mv=%b mr=%b want 0",
               I_Req_Ready, D_Req_Ready, I_Rvalid, D_Rvalid, M_Req_Valid, M_Rready);
    end
    rst = 1'b0;
    I_Req_Valid = 1'b0;
    rsp_wait = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_starve();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
